chaining_record_table: RTL

- Holds the in-flight instruction records (chaining records) that feed the per-slot write-hazard checkers of one lane.
- Allocates a record when an instruction issues to the lane, and sets elementMask bits as the lane's VRF write port commits elements.
- Frees a record on instruction release.
- Presents all slots each cycle as registered, flattened record buses, so checkers see stable state with no combinational path from this cycle's inputs.

---
 rtl/chaining_record_table.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/chaining_record_table.sv
// rtl/chaining_record_table.sv - in-flight chaining record table for one lane's write-hazard checkers
// Optional feature macro: CHAINING_AUTO_RETIRE_EN (frees a slot once its elementMask is all-ones)
module chaining_record_table #(
  parameter int CHAINING_SIZE = 4,
  parameter int MASK_W        = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic                          alloc_vd_valid,
  input  logic [4:0]                    alloc_vd_bits,
  input  logic                          alloc_vs1_valid,
  input  logic [4:0]                    alloc_vs1_bits,
  input  logic [4:0]                    alloc_vs2,
  input  logic [2:0]                    alloc_instIndex,
  input  logic                          alloc_gather,
  input  logic                          alloc_gather16,
  input  logic                          alloc_onlyRead,
  input  logic                          write_valid,
  input  logic [2:0]                    write_instIndex,
  input  logic [4:0]                    write_vd,
  input  logic [1:0]                    write_offset,
  input  logic                          release_valid,
  input  logic [2:0]                    release_instIndex,
  output logic [CHAINING_SIZE-1:0]        record_valid,
  output logic [CHAINING_SIZE-1:0]        record_vd_valid,
  output logic [5*CHAINING_SIZE-1:0]      record_vd_bits,
  output logic [CHAINING_SIZE-1:0]        record_vs1_valid,
  output logic [5*CHAINING_SIZE-1:0]      record_vs1_bits,
  output logic [5*CHAINING_SIZE-1:0]      record_vs2,
  output logic [3*CHAINING_SIZE-1:0]      record_instIndex,
  output logic [CHAINING_SIZE-1:0]        record_gather,
  output logic [CHAINING_SIZE-1:0]        record_gather16,
  output logic [CHAINING_SIZE-1:0]        record_onlyRead,
  output logic [MASK_W*CHAINING_SIZE-1:0] record_elementMask,
  output logic                          full,
  output logic                          empty,
  output logic                          dup_error
);

  // Per-slot record state
  logic [CHAINING_SIZE-1:0] recValid;
  logic [CHAINING_SIZE-1:0] recVdValid;
  logic [4:0]               recVdBits   [CHAINING_SIZE];
  logic [CHAINING_SIZE-1:0] recVs1Valid;
  logic [4:0]               recVs1Bits  [CHAINING_SIZE];
  logic [4:0]               recVs2      [CHAINING_SIZE];
  logic [2:0]               recInstIndex[CHAINING_SIZE];
  logic [CHAINING_SIZE-1:0] recGather;
  logic [CHAINING_SIZE-1:0] recGather16;
  logic [CHAINING_SIZE-1:0] recOnlyRead;
  logic [MASK_W-1:0]        recMask     [CHAINING_SIZE];
  logic                     fullReg;
  logic                     emptyReg;
  logic                     dupReg;

  // Next-state helpers
  logic                     allocFire;
  logic                     freeFound;
  logic                     dupHit;
  logic [CHAINING_SIZE-1:0] allocHit;
  logic [CHAINING_SIZE-1:0] relHit;
  logic [CHAINING_SIZE-1:0] wrHit;
  logic [CHAINING_SIZE-1:0] retireHit;
  logic [CHAINING_SIZE-1:0] nextValid;
  logic [4:0]               writeDelta  [CHAINING_SIZE];
  logic [MASK_W-1:0]        maskNext    [CHAINING_SIZE];

  // Ready depends only on registered state; a release this cycle cannot bypass into it
  assign alloc_ready = ~fullReg;
  assign allocFire   = alloc_valid & ~fullReg;

  // Pick the lowest free slot from the pre-release free set and detect a resident duplicate index
  always_comb begin
    allocHit  = '0;
    freeFound = 1'b0;
    dupHit    = 1'b0;
    for (int i = 0; i < CHAINING_SIZE; i++) begin
      if (!freeFound && !recValid[i]) begin
        allocHit[i] = allocFire;
        freeFound   = 1'b1;
      end
      if (recValid[i] && (recInstIndex[i] == alloc_instIndex)) begin
        dupHit = 1'b1;
      end
    end
  end

  // Release, element-write and optional auto-retire decisions per slot
  always_comb begin
    relHit    = '0;
    wrHit     = '0;
    retireHit = '0;
    for (int i = 0; i < CHAINING_SIZE; i++) begin
      relHit[i]     = release_valid & recValid[i] & (recInstIndex[i] == release_instIndex);
      // Modulo-32 distance from the group base handles register wrap-around for free
      writeDelta[i] = write_vd - recVdBits[i];
      wrHit[i]      = write_valid & recValid[i] & recVdValid[i]
                    & (recInstIndex[i] == write_instIndex)
                    & (writeDelta[i][4:3] == 2'b00);
      maskNext[i]   = recMask[i];
      // Release takes priority over a same-cycle write to the same slot
      if (wrHit[i] && !relHit[i]) begin
        maskNext[i][{writeDelta[i][2:0], write_offset}] = 1'b1;
      end
`ifdef CHAINING_AUTO_RETIRE_EN
      retireHit[i] = recValid[i] & recVdValid[i] & ~relHit[i] & (&maskNext[i]);
`endif
    end
    nextValid = (recValid & ~relHit & ~retireHit) | allocHit;
  end

  // Record registers, mask accumulation and the coherent full/empty/dup status
  always_ff @(posedge clock) begin
    if (reset) begin
      recValid    <= '0;
      recVdValid  <= '0;
      recVs1Valid <= '0;
      recGather   <= '0;
      recGather16 <= '0;
      recOnlyRead <= '0;
      fullReg     <= 1'b0;
      emptyReg    <= 1'b1;
      dupReg      <= 1'b0;
      for (int i = 0; i < CHAINING_SIZE; i++) begin
        recVdBits[i]    <= '0;
        recVs1Bits[i]   <= '0;
        recVs2[i]       <= '0;
        recInstIndex[i] <= '0;
        recMask[i]      <= '0;
      end
    end else begin
      recValid <= nextValid;
      fullReg  <= &nextValid;
      emptyReg <= ~|nextValid;
      dupReg   <= dupReg | (allocFire & dupHit);
      for (int i = 0; i < CHAINING_SIZE; i++) begin
        if (allocHit[i]) begin
          recVdValid[i]   <= alloc_vd_valid;
          recVdBits[i]    <= alloc_vd_bits;
          recVs1Valid[i]  <= alloc_vs1_valid;
          recVs1Bits[i]   <= alloc_vs1_bits;
          recVs2[i]       <= alloc_vs2;
          recInstIndex[i] <= alloc_instIndex;
          recGather[i]    <= alloc_gather;
          recGather16[i]  <= alloc_gather16;
          recOnlyRead[i]  <= alloc_onlyRead;
          recMask[i]      <= '0;
        end else begin
          recMask[i] <= maskNext[i];
        end
      end
    end
  end

  // Flatten the slot arrays onto the output buses
  always_comb begin
    record_vd_bits     = '0;
    record_vs1_bits    = '0;
    record_vs2         = '0;
    record_instIndex   = '0;
    record_elementMask = '0;
    for (int i = 0; i < CHAINING_SIZE; i++) begin
      record_vd_bits[5*i +: 5]              = recVdBits[i];
      record_vs1_bits[5*i +: 5]             = recVs1Bits[i];
      record_vs2[5*i +: 5]                  = recVs2[i];
      record_instIndex[3*i +: 3]            = recInstIndex[i];
      record_elementMask[MASK_W*i +: MASK_W] = recMask[i];
    end
  end

  assign record_valid     = recValid;
  assign record_vd_valid  = recVdValid;
  assign record_vs1_valid = recVs1Valid;
  assign record_gather    = recGather;
  assign record_gather16  = recGather16;
  assign record_onlyRead  = recOnlyRead;
  assign full             = fullReg;
  assign empty            = emptyReg;
  assign dup_error        = dupReg;

endmodule
